// File: rtl/bpc_symbol_decoder.sv
// Bit-plane-compression symbol decoder.
// Parses an MSB-first stream of prefix-coded DBX symbols out of DATA_W-bit
// words and rebuilds one block: base word plus DATA_W+1 delta bit-planes.
// blk_o layout: [BLK_W-1 -: DATA_W] = base, [k*(BLOCK_SIZE-1) +: BLOCK_SIZE-1] = dbp[k].
module bpc_symbol_decoder #(
    parameter int DATA_W       = 8,
    parameter int BLOCK_SIZE   = 8,
    parameter int LOG_DATA_W   = 3,
    parameter int MAX_SYMB_LEN = 8,
    parameter int BUF_W        = 16
) (
    input  logic                                          clk_i,
    input  logic                                          rst_ni,
    input  logic [DATA_W-1:0]                             in_data_i,
    input  logic                                          in_valid_i,
    output logic                                          in_ready_o,
    output logic [(DATA_W+1)*(BLOCK_SIZE-1)+DATA_W-1:0]   blk_o,
    output logic                                          blk_valid_o,
    input  logic                                          blk_ready_i,
    output logic                                          err_o
);

    localparam int RAW_W  = BLOCK_SIZE - 1;
    localparam int PW     = $clog2(BLOCK_SIZE);
    localparam int BLK_W  = (DATA_W + 1) * RAW_W + DATA_W;
    localparam int FILL_W = $clog2(BUF_W + 1);
    localparam int K_W    = $clog2(DATA_W + 1);
    localparam int RUN_W  = LOG_DATA_W + 1;
    // Free space needed to take a word; never larger than the longest symbol slot.
    localparam int ROOM_I = (BUF_W - DATA_W < MAX_SYMB_LEN) ? BUF_W - DATA_W : MAX_SYMB_LEN;

    localparam logic [FILL_W-1:0] LEN_BASE = FILL_W'(DATA_W);
    localparam logic [FILL_W-1:0] LEN_RAW  = FILL_W'(1 + RAW_W);
    localparam logic [FILL_W-1:0] LEN_ZERO = FILL_W'(2);
    localparam logic [FILL_W-1:0] LEN_RUN  = FILL_W'(3 + LOG_DATA_W);
    localparam logic [FILL_W-1:0] LEN_FIX  = FILL_W'(5);
    localparam logic [FILL_W-1:0] LEN_POS  = FILL_W'(5 + PW);
    localparam logic [FILL_W-1:0] ROOM     = FILL_W'(ROOM_I);
    localparam logic [K_W-1:0]    K_TOP    = K_W'(DATA_W);
    localparam logic [RAW_W-1:0]  ONE_BIT  = {{(RAW_W-1){1'b0}}, 1'b1};
    localparam logic [RAW_W-1:0]  TWO_BIT  = {{(RAW_W-2){1'b0}}, 2'b11};

    typedef enum logic [1:0] {ST_BASE, ST_SYM, ST_OUT} state_t;

    state_t              state_q, state_d;
    logic [BUF_W-1:0]    buf_q, buf_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [K_W-1:0]      k_q, k_d;
    logic [RUN_W-1:0]    run_q, run_d;
    logic [RAW_W-1:0]    prev_q, prev_d;
    logic [BLK_W-1:0]    blk_q, blk_d;
    logic                blk_valid_q, blk_valid_d;
    logic                err_q, err_d;

    logic [FILL_W-1:0]   n_used;
    logic                plane_we;
    logic                sym_err;
    logic [RAW_W-1:0]    x_val;
    logic [RAW_W-1:0]    plane;

    // Symbol fields as they sit at the head of the left-aligned buffer.
    logic [RAW_W-1:0]      raw_fld;
    logic [LOG_DATA_W-1:0] run_fld;
    logic [1:0]            sel_fld;
    logic [PW-1:0]         pos_fld;

    assign raw_fld = buf_q[BUF_W-2 -: RAW_W];
    assign run_fld = buf_q[BUF_W-4 -: LOG_DATA_W];
    assign sel_fld = buf_q[BUF_W-4 -: 2];
    assign pos_fld = buf_q[BUF_W-6 -: PW];

    assign in_ready_o  = (fill_q <= ROOM) && !err_q;
    assign blk_o       = blk_q;
    assign blk_valid_o = blk_valid_q;
    assign err_o       = err_q;

    // Next-state: block FSM, symbol decode, plane write and bit-buffer shift/append.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        run_d       = run_q;
        prev_d      = prev_q;
        blk_d       = blk_q;
        blk_valid_d = blk_valid_q;
        err_d       = err_q;
        n_used      = '0;
        plane_we    = 1'b0;
        sym_err     = 1'b0;
        x_val       = '0;

        if (!err_q) begin
            case (state_q)
                ST_BASE: begin
                    if (fill_q >= LEN_BASE) begin
                        blk_d[BLK_W-1 -: DATA_W] = buf_q[BUF_W-1 -: DATA_W];
                        n_used  = LEN_BASE;
                        k_d     = K_TOP;
                        prev_d  = '0;
                        state_d = ST_SYM;
                    end
                end
                ST_SYM: begin
                    if (run_q != '0) begin
                        // Zero-run continuation: no bits consumed.
                        plane_we = 1'b1;
                        run_d    = run_q - 1'b1;
                    end else if (buf_q[BUF_W-1]) begin
                        if (fill_q >= LEN_RAW) begin
                            x_val    = raw_fld;
                            plane_we = 1'b1;
                            n_used   = LEN_RAW;
                        end
                    end else if (buf_q[BUF_W-2]) begin
                        if (fill_q >= LEN_ZERO) begin
                            plane_we = 1'b1;
                            n_used   = LEN_ZERO;
                        end
                    end else if (buf_q[BUF_W-3]) begin
                        if (fill_q >= LEN_RUN) begin
                            // Run covers this plane and r+1 more; must fit in planes k..0.
                            if (int'(run_fld) + 2 > int'(k_q) + 1) begin
                                sym_err = 1'b1;
                            end else begin
                                plane_we = 1'b1;
                                n_used   = LEN_RUN;
                                run_d    = RUN_W'(run_fld) + 1'b1;
                            end
                        end
                    end else begin
                        case (sel_fld)
                            2'b00: begin
                                if (fill_q >= LEN_FIX) begin
                                    x_val    = '1;
                                    plane_we = 1'b1;
                                    n_used   = LEN_FIX;
                                end
                            end
                            2'b01: begin
                                if (fill_q >= LEN_FIX) begin
                                    plane_we = 1'b1;
                                    n_used   = LEN_FIX;
                                end
                            end
                            2'b10: begin
                                if (fill_q >= LEN_POS) begin
                                    if (int'(pos_fld) > BLOCK_SIZE - 3) begin
                                        sym_err = 1'b1;
                                    end else begin
                                        x_val    = TWO_BIT << pos_fld;
                                        plane_we = 1'b1;
                                        n_used   = LEN_POS;
                                    end
                                end
                            end
                            default: begin
                                if (fill_q >= LEN_POS) begin
                                    if (int'(pos_fld) > BLOCK_SIZE - 2) begin
                                        sym_err = 1'b1;
                                    end else begin
                                        x_val    = ONE_BIT << pos_fld;
                                        plane_we = 1'b1;
                                        n_used   = LEN_POS;
                                    end
                                end
                            end
                        endcase
                    end
                end
                ST_OUT: begin
                    if (blk_ready_i) begin
                        blk_valid_d = 1'b0;
                        state_d     = ST_BASE;
                    end
                end
                default: state_d = ST_BASE;
            endcase
        end

        plane = x_val ^ prev_q;
        if (plane_we) begin
            blk_d[int'(k_q)*RAW_W +: RAW_W] = plane;
            prev_d = plane;
            if (k_q == '0) begin
                state_d     = ST_OUT;
                blk_valid_d = 1'b1;
            end else begin
                k_d = k_q - 1'b1;
            end
        end
        if (sym_err) begin
            err_d = 1'b1;
        end

        buf_d  = buf_q << n_used;
        fill_d = fill_q - n_used;
        if (in_valid_i && in_ready_o) begin
            buf_d  = buf_d | ({in_data_i, {(BUF_W-DATA_W){1'b0}}} >> fill_d);
            fill_d = fill_d + LEN_BASE;
        end
    end

    // State registers; reset discards any partially decoded block.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_BASE;
            buf_q       <= '0;
            fill_q      <= '0;
            k_q         <= '0;
            run_q       <= '0;
            prev_q      <= '0;
            blk_q       <= '0;
            blk_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            fill_q      <= fill_d;
            k_q         <= k_d;
            run_q       <= run_d;
            prev_q      <= prev_d;
            blk_q       <= blk_d;
            blk_valid_q <= blk_valid_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_bpc_symbol_decoder.sv
// Testbench for bpc_symbol_decoder: directed streams plus random blocks
// produced by a symbol-level encoder model.
`timescale 1ns/1ps
module tb_bpc_symbol_decoder;

    localparam int DATA_W       = 8;
    localparam int BLOCK_SIZE   = 8;
    localparam int LOG_DATA_W   = 3;
    localparam int MAX_SYMB_LEN = 8;
    localparam int BUF_W        = 16;
    localparam int RAW_W        = BLOCK_SIZE - 1;
    localparam int BLK_W        = (DATA_W + 1) * RAW_W + DATA_W;

    logic              clk = 1'b0;
    logic              rst_ni = 1'b0;
    logic [DATA_W-1:0] in_data_i = '0;
    logic              in_valid_i = 1'b0;
    logic              in_ready_o;
    logic [BLK_W-1:0]  blk_o;
    logic              blk_valid_o;
    logic              blk_ready_i = 1'b0;
    logic              err_o;

    bpc_symbol_decoder #(
        .DATA_W(DATA_W), .BLOCK_SIZE(BLOCK_SIZE), .LOG_DATA_W(LOG_DATA_W),
        .MAX_SYMB_LEN(MAX_SYMB_LEN), .BUF_W(BUF_W)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .in_data_i(in_data_i), .in_valid_i(in_valid_i),
        .in_ready_o(in_ready_o), .blk_o(blk_o), .blk_valid_o(blk_valid_o),
        .blk_ready_i(blk_ready_i), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    bit                bits_q[$];
    logic [DATA_W-1:0] word_q[$];
    logic [BLK_W-1:0]  exp_q[$];
    logic [BLK_W-1:0]  rx_q[$];
    int saw_valid, saw_err, rdy_after_err, hold_bad;

    function automatic void put(input int unsigned v, input int w);
        for (int i = w - 1; i >= 0; i--) bits_q.push_back(bit'((v >> i) & 1));
    endfunction

    // Pad with ones and cut the bit list into MSB-first words.
    function automatic void finish_stream();
        logic [DATA_W-1:0] w;
        for (int i = 0; i < 64; i++) bits_q.push_back(1'b1);
        while (bits_q.size() % DATA_W != 0) bits_q.push_back(1'b1);
        while (bits_q.size() > 0) begin
            for (int b = DATA_W - 1; b >= 0; b--) w[b] = bits_q.pop_front();
            word_q.push_back(w);
        end
    endfunction

    // Encoder model: pick symbols plane by plane, emit their bits, and
    // rebuild the expected planes with dbp = x ^ previous dbp.
    task automatic gen_random_block();
        logic [DATA_W-1:0] base;
        logic [RAW_W-1:0]  planes [0:DATA_W];
        logic [RAW_W-1:0]  prev;
        logic [RAW_W-1:0]  x;
        logic [BLK_W-1:0]  blk;
        int k, kind, nx, r, p;
        base = DATA_W'($urandom);
        put(base, DATA_W);
        prev = '0;
        k = DATA_W;
        while (k >= 0) begin
            kind = int'($urandom_range(0, 6));
            nx = 1;
            x = '0;
            case (kind)
                0: begin x = RAW_W'($urandom); put(1, 1); put(x, RAW_W); end
                2: begin
                    if (k >= 1) begin
                        r = int'($urandom_range(0, (k - 1 < 7) ? k - 1 : 7));
                        put(1, 3); put(r, 3); nx = r + 2;
                    end else put(1, 2);
                end
                3: begin x = '1; put(0, 5); end
                4: begin put(1, 5); end
                5: begin p = int'($urandom_range(0, BLOCK_SIZE - 3)); x = RAW_W'(3 << p); put(2, 5); put(p, 3); end
                6: begin p = int'($urandom_range(0, BLOCK_SIZE - 2)); x = RAW_W'(1 << p); put(3, 5); put(p, 3); end
                default: put(1, 2);
            endcase
            repeat (nx) begin
                planes[k] = x ^ prev;
                prev = planes[k];
                k--;
            end
        end
        blk[BLK_W-1 -: DATA_W] = base;
        for (int i = 0; i <= DATA_W; i++) blk[i*RAW_W +: RAW_W] = planes[i];
        exp_q.push_back(blk);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        in_valid_i = 1'b0;
        blk_ready_i = 1'b0;
        bits_q.delete(); word_q.delete(); exp_q.delete(); rx_q.delete();
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
    endtask

    // Feed word_q and collect blocks; rdy_mode 0=always ready, 1=random, 2=stall 5 on first block.
    task automatic drive_stream(input int max_cyc, input int nblk, input int vld_pct, input int rdy_mode);
        logic [BLK_W-1:0] held_blk;
        logic held, r;
        int stall_left;
        rx_q.delete();
        saw_valid = 0; saw_err = 0; rdy_after_err = 0; hold_bad = 0;
        held = 1'b0; held_blk = '0; stall_left = 5;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            if (held && (blk_valid_o !== 1'b1 || blk_o !== held_blk)) hold_bad++;
            if (blk_valid_o === 1'b1) saw_valid = 1;
            if (err_o === 1'b1) begin
                saw_err = 1;
                if (in_ready_o !== 1'b0) rdy_after_err++;
            end
            case (rdy_mode)
                0: r = 1'b1;
                1: r = ($urandom_range(0, 99) < 60);
                default: begin
                    if (blk_valid_o && stall_left > 0) begin r = 1'b0; stall_left--; end
                    else r = 1'b1;
                end
            endcase
            blk_ready_i = r;
            if (blk_valid_o && r) begin
                rx_q.push_back(blk_o);
                held = 1'b0;
            end else begin
                held = blk_valid_o;
                held_blk = blk_o;
            end
            if (word_q.size() > 0 && $urandom_range(0, 99) < vld_pct) begin
                in_valid_i = 1'b1;
                in_data_i = word_q[0];
                if (in_ready_o) void'(word_q.pop_front());
            end else begin
                in_valid_i = 1'b0;
                in_data_i = DATA_W'($urandom);
            end
            if (nblk > 0 && rx_q.size() >= nblk) break;
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        #3;
        n_cmp++; if (in_ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready_o); end
        n_cmp++; if (blk_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_blk_valid got=%b want=0", blk_valid_o); end
        n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b want=0", err_o); end
        n_cmp++; if (blk_o !== '0) begin n_bad++; $display("FAIL reset_blk got=%h want=0", blk_o); end
        do_reset();
        @(negedge clk);
        n_cmp++; if (in_ready_o !== 1'b1 || blk_valid_o !== 1'b0 || err_o !== 1'b0) begin
            n_bad++; $display("FAIL reset_idle got rdy=%b vld=%b err=%b want 1/0/0", in_ready_o, blk_valid_o, err_o);
        end
    endtask

    task automatic test_all_zero();
        logic [BLK_W-1:0] want, got;
        do_reset();
        put(8'h5A, 8);
        repeat (9) put(1, 2);
        finish_stream();
        drive_stream(200, 1, 100, 0);
        want = {8'h5A, 63'd0};
        got = (rx_q.size() > 0) ? rx_q[0] : 'x;
        n_cmp++; if (rx_q.size() != 1) begin n_bad++; $display("FAIL zero_count got=%0d want=1", rx_q.size()); end
        n_cmp++; if (got !== want) begin n_bad++; $display("FAIL zero_block got=%h want=%h", got, want); end
        n_cmp++; if (saw_err != 0) begin n_bad++; $display("FAIL zero_err got=%0d want=0", saw_err); end
    endtask

    task automatic test_run_overflow();
        do_reset();
        put(8'h00, 8);
        put(1, 1); put(7'b1010101, 7);
        put(1, 3); put(7, 3);
        finish_stream();
        drive_stream(60, 0, 100, 0);
        n_cmp++; if (saw_err != 1) begin n_bad++; $display("FAIL runovf_err got=%0d want=1", saw_err); end
        n_cmp++; if (saw_valid != 0) begin n_bad++; $display("FAIL runovf_valid got=%0d want=0", saw_valid); end
        n_cmp++; if (rdy_after_err != 0) begin n_bad++; $display("FAIL runovf_ready got=%0d want=0", rdy_after_err); end
        n_cmp++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL runovf_sticky got=%b want=1", err_o); end
    endtask

    task automatic test_ones_prev();
        logic [BLK_W-1:0] want, got;
        do_reset();
        put(8'hFF, 8);
        put(0, 5);
        repeat (8) put(1, 2);
        finish_stream();
        drive_stream(200, 1, 100, 0);
        want = {8'hFF, {9{7'h7F}}};
        got = (rx_q.size() > 0) ? rx_q[0] : 'x;
        n_cmp++; if (got !== want) begin n_bad++; $display("FAIL ones_block got=%h want=%h", got, want); end
    endtask

    task automatic test_pair_single_run();
        logic [BLK_W-1:0] want, got;
        do_reset();
        put(8'h01, 8);
        put(3, 5); put(2, 3);
        put(2, 5); put(0, 3);
        put(1, 3); put(5, 3);
        finish_stream();
        drive_stream(200, 1, 100, 0);
        want = {8'h01, 7'h04, 7'h07, {7{7'h07}}};
        got = (rx_q.size() > 0) ? rx_q[0] : 'x;
        n_cmp++; if (got !== want) begin n_bad++; $display("FAIL pairrun_block got=%h want=%h", got, want); end
        n_cmp++; if (saw_err != 0) begin n_bad++; $display("FAIL pairrun_err got=%0d want=0", saw_err); end
    endtask

    task automatic test_back_to_back();
        logic [BLK_W-1:0] got;
        do_reset();
        gen_random_block();
        gen_random_block();
        finish_stream();
        drive_stream(400, 2, 100, 2);
        n_cmp++; if (rx_q.size() != 2) begin n_bad++; $display("FAIL b2b_count got=%0d want=2", rx_q.size()); end
        for (int i = 0; i < 2; i++) begin
            got = (rx_q.size() > i) ? rx_q[i] : 'x;
            n_cmp++; if (got !== exp_q[i]) begin n_bad++; $display("FAIL b2b_block%0d got=%h want=%h", i, got, exp_q[i]); end
        end
        n_cmp++; if (hold_bad != 0) begin n_bad++; $display("FAIL b2b_hold unstable_cycles=%0d want=0", hold_bad); end
    endtask

    task automatic test_bad_symbol();
        for (int s = 0; s < 2; s++) begin
            do_reset();
            put($urandom, 8);
            put(1, 1); put($urandom, 7);
            if (s == 0) begin put(3, 5); put(7, 3); end
            else begin put(2, 5); put(6, 3); end
            finish_stream();
            drive_stream(40, 0, 100, 0);
            n_cmp++; if (saw_err != 1) begin n_bad++; $display("FAIL badsym%0d_err got=%0d want=1", s, saw_err); end
            n_cmp++; if (saw_valid != 0) begin n_bad++; $display("FAIL badsym%0d_valid got=%0d want=0", s, saw_valid); end
            #2 rst_ni = 1'b0;
            #1;
            n_cmp++; if (err_o !== 1'b0 || in_ready_o !== 1'b1) begin
                n_bad++; $display("FAIL badsym%0d_async_rst got err=%b rdy=%b want 0/1", s, err_o, in_ready_o);
            end
            in_valid_i = 1'b0;
            @(negedge clk);
            rst_ni = 1'b1;
        end
    endtask

    task automatic test_async_reset();
        logic [BLK_W-1:0] got;
        do_reset();
        gen_random_block();
        gen_random_block();
        finish_stream();
        drive_stream(6, 1, 100, 0);
        #2 rst_ni = 1'b0;
        #1;
        n_cmp++; if (blk_o !== '0) begin n_bad++; $display("FAIL arst_blk got=%h want=0", blk_o); end
        n_cmp++; if (blk_valid_o !== 1'b0 || err_o !== 1'b0 || in_ready_o !== 1'b1) begin
            n_bad++; $display("FAIL arst_ctrl got vld=%b err=%b rdy=%b want 0/0/1", blk_valid_o, err_o, in_ready_o);
        end
        do_reset();
        gen_random_block();
        finish_stream();
        drive_stream(200, 1, 100, 0);
        got = (rx_q.size() > 0) ? rx_q[0] : 'x;
        n_cmp++; if (got !== exp_q[0]) begin n_bad++; $display("FAIL arst_fresh got=%h want=%h", got, exp_q[0]); end
    endtask

    task automatic test_random();
        int nblk, vpct, rmode;
        logic [BLK_W-1:0] got;
        for (int round = 0; round < 3; round++) begin
            nblk = 4 + round;
            vpct = (round == 0) ? 100 : (round == 1) ? 70 : 40;
            rmode = (round == 0) ? 0 : 1;
            do_reset();
            for (int b = 0; b < nblk; b++) gen_random_block();
            finish_stream();
            drive_stream(150 * nblk + 100, nblk, vpct, rmode);
            n_cmp++; if (rx_q.size() != nblk) begin n_bad++; $display("FAIL rand%0d_count got=%0d want=%0d", round, rx_q.size(), nblk); end
            for (int b = 0; b < nblk; b++) begin
                got = (rx_q.size() > b) ? rx_q[b] : 'x;
                n_cmp++; if (got !== exp_q[b]) begin n_bad++; $display("FAIL rand%0d_block%0d got=%h want=%h", round, b, got, exp_q[b]); end
            end
            n_cmp++; if (hold_bad != 0 || saw_err != 0) begin
                n_bad++; $display("FAIL rand%0d_hold_err got hold=%0d err=%0d want 0/0", round, hold_bad, saw_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_all_zero();
        test_run_overflow();
        test_ones_prev();
        test_pair_single_run();
        test_back_to_back();
        test_bad_symbol();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bpc_symbol_decoder.md
Name: bpc_symbol_decoder

Overview:
- Bit-plane-compression (BPC) decoder: the receive-side counterpart of the EBPC bit-plane encoder.
- Consumes a packed MSB-first compressed bitstream in DATA_W-bit words and parses the prefix-coded DBX symbols.
- Rebuilds one dbp_block_t per block (base word plus DATA_W+1 DBP planes) and hands it to the downstream delta/ZRLE reconstruction stage over a valid/ready interface.

Parameters:
- DATA_W, 8: word width; the base field is DATA_W bits.
- BLOCK_SIZE, 8: words per block; each plane is BLOCK_SIZE-1 bits.
- LOG_DATA_W, 3: width of the zero-run field.
- MAX_SYMB_LEN, 8: longest symbol. Equals max(BLOCK_SIZE, 3+LOG_DATA_W, 5+clog2(BLOCK_SIZE)).
- BUF_W, 16: bit-buffer capacity. Equals MAX_SYMB_LEN+DATA_W.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- in_data_i  in  DATA_W  compressed stream word; bit DATA_W-1 is transmitted first
- in_valid_i  in  1  input word valid
- in_ready_o  out  1  input word accepted when in_valid_i && in_ready_o
- blk_o  out  (DATA_W+1)*(BLOCK_SIZE-1)+DATA_W  decoded dbp_block_t
- blk_valid_o  out  1  blk_o valid
- blk_ready_i  in  1  downstream accepts blk_o
- err_o  out  1  sticky malformed-stream flag

Behaviour:
- Reset: in_ready_o=1, blk_valid_o=0, err_o=0, blk_o=0, fill=0, FSM=BASE.
- Bit buffer:
  - BUF_W bits, left-aligned; fill counter 0..BUF_W.
  - in_ready_o = (fill <= BUF_W-DATA_W) && !err_o.
  - An accepted word is appended below the current fill.
  - Consumption of n bits shifts the buffer left by n.
  - Append and consume may occur in the same cycle: fill' = fill + DATA_W - n.
- FSM BASE:
  - Wait until fill >= DATA_W.
  - Consume DATA_W bits into base.
  - Set plane index k=DATA_W (planes are decoded from k=DATA_W down to 0) and prev=0.
  - Go to SYM.
- FSM SYM: one plane written per cycle. A symbol is decoded only when fill >= its full length. Codes, MSB-first, with resulting DBX value x:
  - "1"+raw(BLOCK_SIZE-1): x=raw.
  - "01": x=0.
  - "001"+r(LOG_DATA_W): zero run of r+2 planes. Load run counter = r+1 and emit x=0 now; following cycles emit x=0 without consuming bits, decrementing the counter to 0.
  - "00000": x=all ones.
  - "00001": x=0.
  - "00010"+p(clog2 BLOCK_SIZE): x has bits p and p+1 set. p > BLOCK_SIZE-3 is an error.
  - "00011"+p: x has bit p set. p > BLOCK_SIZE-2 is an error.
  - "00010" / "00011" with insufficient fill: stall.
- Plane reconstruction:
  - dbp[k] = x XOR prev; prev <= dbp[k]; k decrements.
  - When the plane at k=0 is written, go to OUT.
- Zero run exceeding the remaining planes (r+2 > k+1): set err_o. No planes are written for that symbol.
- FSM OUT:
  - blk_valid_o=1; blk_o is held stable until blk_ready_i.
  - In the handshake cycle: blk_valid_o<=0 next cycle, go to BASE.
  - Buffer filling continues while in OUT; no decoding occurs.
- Error: err_o=1 from the cycle after detection and stays set until reset. in_ready_o is forced to 0, the FSM freezes, and blk_valid_o stays 0.
- Latency: the first blk_valid_o asserts no earlier than 1 cycle after the plane at k=0 is written.
- Throughput: 1 plane per cycle when the buffer is fed.
- Reset mid-block: all state discarded, no partial block is emitted.
- Blocks are not byte-aligned; the next block's base follows the last symbol immediately.

Test Plan:
- Base 0x5A, then 9× "01" (18 bits), stream padded with 1s -> one block: base=0x5A, all dbp=0; in_ready_o never drops for more than 1 cycle.
- Base 0x00, "1"+7'b1010101, then "001"+3'b111 (run 9 > 8 remaining) -> err_o=1 one cycle later, in_ready_o=0 thereafter, blk_valid_o never asserts.
- Base 0xFF, "00000", then 8× "01" -> dbp[8..0] all = 7'h7F (prev propagates through zero DBX).
- Base 0x01, "00011"+3'd2, "00010"+3'd0, then "001"+3'd5 (run 7) -> dbp[8]=7'h04, dbp[7]=7'h07, dbp[6..0]=7'h07.
- Two back-to-back blocks with blk_ready_i=0 for 5 cycles after the first blk_valid_o -> blk_o stable during the stall, second block decoded correctly after the handshake, no bits lost.
- "00011"+3'd7 -> err_o=1. Separately, assert rst_ni low mid-run -> all outputs return to reset values asynchronously.
